// File: rtl/nbit_serial_adder_subtractor.sv
// Digit-serial adder/subtractor with start/ready/done handshake.
// Ports: clk_in, reset_in (sync, active-high), start_in, a_in, b_in, c_in,
//        control_in (0=add, 1=sub) in; ready_out, done_out, result_out,
//        carry_out (carry or borrow), overflow_out (signed) out.
module nbit_serial_adder_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             control_in,
    output logic             ready_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cy_q, cy_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]       dsum;
    logic                 msb_cin;
    logic [WIDTH+DIGIT-1:0] shifted;

    // b_q already holds ~B for subtraction, so the digit path is a plain add.
    assign dsum = {1'b0, a_q[DIGIT-1:0]}
                + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, cy_q};

    // Carry into the digit MSB recovered from its sum bit.
    assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];

    // New digit enters at the top; after NDIG shifts digit 0 sits at the LSB.
    assign shifted = {dsum[DIGIT-1:0], res_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cy_d     = cy_q;
        sub_d    = sub_q;
        res_d    = res_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cy_d  = dsum[DIGIT];
                res_d = shifted[WIDTH+DIGIT-1:DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = shifted[WIDTH+DIGIT-1:DIGIT];
                    // Borrow is the inverted carry of A + ~B + ~bin.
                    cout_d   = dsum[DIGIT] ^ sub_q;
                    ovf_d    = msb_cin ^ dsum[DIGIT];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept from IDLE or DONE (back-to-back issue).
        if (start_in && state_q != RUN) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = a_in;
            b_d     = control_in ? ~b_in : b_in;
            cy_d    = c_in ^ control_in;
            sub_d   = control_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cy_q     <= 1'b0;
            sub_q    <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cy_q     <= cy_d;
            sub_q    <= sub_d;
            res_q    <= res_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready_out    = (state_q != RUN);
    assign done_out     = (state_q == DONE);
    assign result_out   = result_q;
    assign carry_out    = cout_q;
    assign overflow_out = ovf_q;

endmodule
